// File: rtl/mux21_pkg.sv
// Shared constants for the registered 2:1 multiplexer.
// Holds the legal parameter ranges and defaults so the top-level
// elaboration checks, the interface and the bench all agree on them.
package mux21_pkg;

    localparam int WIDTH_MIN       = 1;
    localparam int WIDTH_MAX       = 64;
    localparam int LATENCY_MIN     = 1;
    localparam int LATENCY_MAX     = 8;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_LATENCY = 1;

endpackage

// File: rtl/mux21_if.sv
// Data bundle for mux21.
// Ports (master = data source, slave = the mux):
//   datain_0  WIDTH  passed when select = 0
//   datain_1  WIDTH  passed when select = 1
//   select    1      1 -> datain_1, anything else -> datain_0
//   out       WIDTH  registered mux result
interface mux21_if import mux21_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] datain_0;
    logic [WIDTH-1:0] datain_1;
    logic             select;
    logic [WIDTH-1:0] out;

    modport master (
        output datain_0,
        output datain_1,
        output select,
        input  out
    );

    modport slave (
        input  datain_0,
        input  datain_1,
        input  select,
        output out
    );
endinterface

// File: rtl/mux21_pipe_reg.sv
// One pipeline stage: WIDTH-bit register with synchronous active-low clear.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous clear, active-low; wins over d
//   d      next value
//   q      registered value
module mux21_pipe_reg import mux21_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mux21.sv
// Registered 2:1 data multiplexer.
// The selected input is pushed through LATENCY register stages every cycle
// (no enable, no stall); out is the last stage.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset; clears every stage
//   bus    mux21_if.slave: datain_0, datain_1, select in; out out
module mux21 import mux21_pkg::*; #(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic         clk,
    input  logic         rst_n,
    mux21_if.slave       bus
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("mux21: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("mux21: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
    end

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] stage [LATENCY];

    // An if/else rather than ?: so an unknown select falls to datain_0
    // instead of merging both inputs into X.
    always_comb begin
        sel_data = bus.datain_0;
        if (bus.select == 1'b1) begin
            sel_data = bus.datain_1;
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        if (k == 0) begin : g_head
            mux21_pipe_reg #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (sel_data),
                .q     (stage[k])
            );
        end else begin : g_tail
            mux21_pipe_reg #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (stage[k-1]),
                .q     (stage[k])
            );
        end
    end

    assign bus.out = stage[LATENCY-1];

endmodule

// File: tb/tb_mux21.sv
// Directed bench for mux21: three instances (4-bit/latency 1, 4-bit/latency 3,
// 8-bit/latency 1) sharing clock and reset. Inputs change 1 time unit after a
// rising edge and outputs are read at the same point.
module tb_mux21;
    import mux21_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mux21_if #(.WIDTH(4)) bus_l1 ();
    mux21_if #(.WIDTH(4)) bus_l3 ();
    mux21_if #(.WIDTH(8)) bus_w8 ();

    mux21 #(.WIDTH(4), .LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(bus_l1.slave));
    mux21 #(.WIDTH(4), .LATENCY(3)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(bus_l3.slave));
    mux21 #(.WIDTH(8), .LATENCY(1)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(bus_w8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [3:0] d0, input logic [3:0] d1, input logic sel);
        bus_l1.datain_0 = d0;
        bus_l1.datain_1 = d1;
        bus_l1.select   = sel;
        bus_l3.datain_0 = d0;
        bus_l3.datain_1 = d1;
        bus_l3.select   = sel;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive4(4'd12, 4'd10, 1'b0);
        bus_w8.datain_0 = 8'h5A;
        bus_w8.datain_1 = 8'hA5;
        bus_w8.select   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (bus_l1.out !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_l1 edge %0d: got %0d want 0", i, bus_l1.out);
            end
            n_cmp++;
            if (bus_l3.out !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_l3 edge %0d: got %0d want 0", i, bus_l3.out);
            end
            n_cmp++;
            if (bus_w8.out !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_w8 edge %0d: got %h want 00", i, bus_w8.out);
            end
        end
    endtask

    task automatic test_select0();
        logic [3:0] exp_l3 [3];
        exp_l3[0] = 4'd0;
        exp_l3[1] = 4'd0;
        exp_l3[2] = 4'd12;
        rst_n = 1'b1;
        drive4(4'd12, 4'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus_l1.out !== 4'd12) begin
                n_bad++;
                $display("FAIL sel0_l1 edge %0d: got %0d want 12", i, bus_l1.out);
            end
            n_cmp++;
            if (bus_l3.out !== exp_l3[i]) begin
                n_bad++;
                $display("FAIL sel0_l3 edge %0d: got %0d want %0d", i, bus_l3.out, exp_l3[i]);
            end
        end
    endtask

    task automatic test_select1();
        logic [3:0] exp_l3 [3];
        exp_l3[0] = 4'd12;
        exp_l3[1] = 4'd12;
        exp_l3[2] = 4'd10;
        drive4(4'd12, 4'd10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus_l1.out !== 4'd10) begin
                n_bad++;
                $display("FAIL sel1_l1 edge %0d: got %0d want 10", i, bus_l1.out);
            end
            n_cmp++;
            if (bus_l3.out !== exp_l3[i]) begin
                n_bad++;
                $display("FAIL sel1_l3 edge %0d: got %0d want %0d", i, bus_l3.out, exp_l3[i]);
            end
        end
    endtask

    // Pipelines hold 10 on entry. Cycle i drives select = i%2 (0 -> 12, 1 -> 10).
    // Latency 1: out after edge i is that cycle's pick; latency 3: pick of i-2.
    task automatic test_toggle();
        logic [3:0] exp_l3 [8] = '{4'd10, 4'd10, 4'd12, 4'd10, 4'd12, 4'd10, 4'd12, 4'd10};
        logic [3:0] exp_l1 [8] = '{4'd12, 4'd10, 4'd12, 4'd10, 4'd12, 4'd10, 4'd12, 4'd10};
        for (int i = 0; i < 8; i++) begin
            drive4(4'd12, 4'd10, i[0]);
            tick();
            n_cmp++;
            if (bus_l1.out !== exp_l1[i]) begin
                n_bad++;
                $display("FAIL toggle_l1 cycle %0d: got %0d want %0d", i, bus_l1.out, exp_l1[i]);
            end
            n_cmp++;
            if (bus_l3.out !== exp_l3[i]) begin
                n_bad++;
                $display("FAIL toggle_l3 cycle %0d: got %0d want %0d", i, bus_l3.out, exp_l3[i]);
            end
        end
    endtask

    // One reset edge mid-toggle (that cycle drives select=0), then toggling
    // resumes with select=1 first: 0,0 flushed, then 10,12,10.
    task automatic test_midstream_reset();
        logic [3:0] exp_l3 [5] = '{4'd0, 4'd0, 4'd10, 4'd12, 4'd10};
        rst_n = 1'b0;
        drive4(4'd12, 4'd10, 1'b0);
        tick();
        n_cmp++;
        if (bus_l3.out !== 4'd0) begin
            n_bad++;
            $display("FAIL midrst_l3 reset edge: got %0d want 0", bus_l3.out);
        end
        n_cmp++;
        if (bus_l1.out !== 4'd0) begin
            n_bad++;
            $display("FAIL midrst_l1 reset edge: got %0d want 0", bus_l1.out);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            drive4(4'd12, 4'd10, ~j[0]);
            tick();
            n_cmp++;
            if (bus_l3.out !== exp_l3[j]) begin
                n_bad++;
                $display("FAIL midrst_l3 post edge %0d: got %0d want %0d", j, bus_l3.out, exp_l3[j]);
            end
        end
    endtask

    task automatic test_width_edges();
        bus_w8.datain_0 = 8'h00;
        bus_w8.datain_1 = 8'hFF;
        bus_w8.select   = 1'b1;
        tick();
        n_cmp++;
        if (bus_w8.out !== 8'hFF) begin
            n_bad++;
            $display("FAIL width_sel1: got %h want ff", bus_w8.out);
        end
        bus_w8.select = 1'b0;
        tick();
        n_cmp++;
        if (bus_w8.out !== 8'h00) begin
            n_bad++;
            $display("FAIL width_sel0: got %h want 00", bus_w8.out);
        end
        bus_w8.select = 1'b1;
        tick();
        n_cmp++;
        if (bus_w8.out !== 8'hFF) begin
            n_bad++;
            $display("FAIL width_sel1_again: got %h want ff", bus_w8.out);
        end
        bus_w8.select = 1'bx;
        tick();
        n_cmp++;
        if (bus_w8.out !== 8'h00) begin
            n_bad++;
            $display("FAIL width_selx: got %h want 00", bus_w8.out);
        end
        bus_w8.datain_0 = 8'hA5;
        bus_w8.datain_1 = 8'h5A;
        bus_w8.select   = 1'b1;
        tick();
        n_cmp++;
        if (bus_w8.out !== 8'h5A) begin
            n_bad++;
            $display("FAIL width_mixed: got %h want 5a", bus_w8.out);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive4(4'd0, 4'd0, 1'b0);
        bus_w8.datain_0 = 8'h00;
        bus_w8.datain_1 = 8'h00;
        bus_w8.select   = 1'b0;
        #1;
        test_reset();
        test_select0();
        test_select1();
        test_toggle();
        test_midstream_reset();
        test_width_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
